// File: rtl/string_match_pkg.sv
// Shared types and constants for the multi-lane string matcher:
// controller state encoding, default sizing, and slice helpers that
// split an MD5 digest into its {a,b,c,d} words.
package string_match_pkg;

  localparam int DEF_STR_LEN   = 19;
  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_CNT_W     = 16;
  localparam int HASH_W        = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digest word accessors; the digest is packed as {a,b,c,d}.
  function automatic logic [31:0] hash_a(input logic [HASH_W-1:0] h);
    return h[127:96];
  endfunction

  function automatic logic [31:0] hash_b(input logic [HASH_W-1:0] h);
    return h[95:64];
  endfunction

  function automatic logic [31:0] hash_c(input logic [HASH_W-1:0] h);
    return h[63:32];
  endfunction

  function automatic logic [31:0] hash_d(input logic [HASH_W-1:0] h);
    return h[31:0];
  endfunction

endpackage

// File: rtl/hash_compare_lane.sv
// One return lane: compares the returned digest against the target and
// passes the tag and message through for the lowest-tag selector.
module hash_compare_lane
  import string_match_pkg::*;
#(
  parameter int MSG_W = 8 * DEF_STR_LEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              ret_valid_i,
  input  logic [HASH_W-1:0] ret_hash_i,
  input  logic [HASH_W-1:0] target_hash_i,
  input  logic [CNT_W-1:0]  ret_tag_i,
  input  logic [MSG_W-1:0]  ret_msg_i,
  output logic              match_o,
  output logic [CNT_W-1:0]  tag_o,
  output logic [MSG_W-1:0]  msg_o
);

  // A lane only matches when it actually presents a return this cycle.
  assign match_o = ret_valid_i
                 && (hash_a(ret_hash_i) == hash_a(target_hash_i))
                 && (hash_b(ret_hash_i) == hash_b(target_hash_i))
                 && (hash_c(ret_hash_i) == hash_c(target_hash_i))
                 && (hash_d(ret_hash_i) == hash_d(target_hash_i));

  assign tag_o = ret_tag_i;
  assign msg_o = ret_msg_i;

endmodule

// File: rtl/string_process_match_multi.sv
// Multi-lane string buffer / matcher. Bytes shift into a STR_LEN-char
// window; each accepted byte dispatches the window round-robin to the
// MD5 lanes tagged with its byte index. Returned digests are compared
// to the target and the lowest-tag match is kept for readout.
// Optional build macro: STRING_MATCH_COUNT_EN (adds proc_match_count).
module string_process_match_multi
  import string_match_pkg::*;
#(
  parameter int STR_LEN   = DEF_STR_LEN,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           proc_start,
  input  logic [CNT_W-1:0]               proc_num_bytes,
  input  logic [7:0]                     proc_data,
  input  logic                           proc_data_valid,
  input  logic                           proc_match_char_next,
  input  logic [HASH_W-1:0]              proc_target_hash,
  output logic                           proc_done,
  output logic                           proc_match,
  output logic [CNT_W-1:0]               proc_byte_pos,
  output logic [7:0]                     proc_match_char,
  output logic [CNT_W-1:0]               proc_match_count,
  output logic [8*STR_LEN-1:0]           md5_msg,
  output logic [CNT_W-1:0]               md5_tag,
  output logic [NUM_LANES-1:0]           md5_msg_valid,
  input  logic [NUM_LANES*HASH_W-1:0]    md5_ret_hash,
  input  logic [NUM_LANES*8*STR_LEN-1:0] md5_ret_msg,
  input  logic [NUM_LANES*CNT_W-1:0]     md5_ret_tag,
  input  logic [NUM_LANES-1:0]           md5_ret_valid
);

  localparam int MSG_W = 8 * STR_LEN;
  localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     num_bytes_q, num_bytes_d;
  logic [MSG_W-1:0]     window_q, window_d;
  logic [CNT_W-1:0]     sent_count_q, sent_count_d;
  logic [CNT_W-1:0]     ret_count_q, ret_count_d;
  logic [PTR_W-1:0]     lane_ptr_q, lane_ptr_d;
  logic [MSG_W-1:0]     md5_msg_q, md5_msg_d;
  logic [CNT_W-1:0]     md5_tag_q, md5_tag_d;
  logic [NUM_LANES-1:0] md5_valid_q, md5_valid_d;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     byte_pos_q, byte_pos_d;
  logic [MSG_W-1:0]     match_msg_q, match_msg_d;

  logic [MSG_W-1:0]     window_shift;
  logic [NUM_LANES-1:0] lane_match;
  logic [CNT_W-1:0]     lane_tag [NUM_LANES];
  logic [MSG_W-1:0]     lane_msg [NUM_LANES];
  logic                 best_found;
  logic [CNT_W-1:0]     best_tag;
  logic [MSG_W-1:0]     best_msg;
  logic [3:0]           ret_hits;
  logic [CNT_W:0]       ret_sum;
  logic [CNT_W-1:0]     ret_capped;

  assign window_shift = {window_q[MSG_W-9:0], proc_data};

  // Per-lane digest comparators.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      hash_compare_lane #(
        .MSG_W (MSG_W),
        .CNT_W (CNT_W)
      ) u_lane (
        .ret_valid_i   (md5_ret_valid[gi]),
        .ret_hash_i    (md5_ret_hash[gi*HASH_W +: HASH_W]),
        .target_hash_i (proc_target_hash),
        .ret_tag_i     (md5_ret_tag[gi*CNT_W +: CNT_W]),
        .ret_msg_i     (md5_ret_msg[gi*MSG_W +: MSG_W]),
        .match_o       (lane_match[gi]),
        .tag_o         (lane_tag[gi]),
        .msg_o         (lane_msg[gi])
      );
    end
  endgenerate

  // Pick the lowest-tag match among lanes and count returns this cycle.
  always_comb begin
    best_found = 1'b0;
    best_tag   = '0;
    best_msg   = '0;
    ret_hits   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (md5_ret_valid[i]) begin
        ret_hits = ret_hits + 4'd1;
      end
      if (lane_match[i] && (!best_found || (lane_tag[i] < best_tag))) begin
        best_found = 1'b1;
        best_tag   = lane_tag[i];
        best_msg   = lane_msg[i];
      end
    end
    ret_sum    = {1'b0, ret_count_q} + (CNT_W+1)'(ret_hits);
    ret_capped = (ret_sum > {1'b0, num_bytes_q}) ? num_bytes_q : ret_sum[CNT_W-1:0];
  end

  // Next-state logic: batch control, dispatch, return accounting, readout.
  always_comb begin
    state_d      = state_q;
    num_bytes_d  = num_bytes_q;
    window_d     = window_q;
    sent_count_d = sent_count_q;
    ret_count_d  = ret_count_q;
    lane_ptr_d   = lane_ptr_q;
    md5_msg_d    = md5_msg_q;
    md5_tag_d    = md5_tag_q;
    md5_valid_d  = '0;
    match_d      = match_q;
    byte_pos_d   = byte_pos_q;
    match_msg_d  = match_msg_q;

    if (proc_start) begin
      // A start always wins, even over a byte presented in the same cycle.
      state_d      = RUN;
      num_bytes_d  = proc_num_bytes;
      window_d     = '0;
      sent_count_d = '0;
      ret_count_d  = '0;
      lane_ptr_d   = '0;
      md5_msg_d    = '0;
      md5_tag_d    = '0;
      match_d      = 1'b0;
      byte_pos_d   = '0;
      match_msg_d  = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (proc_data_valid && (sent_count_q < num_bytes_q)) begin
            window_d     = window_shift;
            md5_msg_d    = window_shift;
            md5_tag_d    = sent_count_q;
            md5_valid_d  = NUM_LANES'(1) << lane_ptr_q;
            lane_ptr_d   = (lane_ptr_q == PTR_W'(NUM_LANES - 1)) ? '0 : lane_ptr_q + 1'b1;
            sent_count_d = sent_count_q + CNT_W'(1);
          end
          ret_count_d = ret_capped;
          if (best_found) begin
            match_d = 1'b1;
            if (!match_q || (best_tag < byte_pos_q)) begin
              byte_pos_d  = best_tag;
              match_msg_d = best_msg;
            end
          end
          if (ret_count_q == num_bytes_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (proc_match_char_next) begin
            match_msg_d = {match_msg_q[MSG_W-9:0], 8'h00};
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      num_bytes_q  <= '0;
      window_q     <= '0;
      sent_count_q <= '0;
      ret_count_q  <= '0;
      lane_ptr_q   <= '0;
      md5_msg_q    <= '0;
      md5_tag_q    <= '0;
      md5_valid_q  <= '0;
      match_q      <= 1'b0;
      byte_pos_q   <= '0;
      match_msg_q  <= '0;
    end else begin
      state_q      <= state_d;
      num_bytes_q  <= num_bytes_d;
      window_q     <= window_d;
      sent_count_q <= sent_count_d;
      ret_count_q  <= ret_count_d;
      lane_ptr_q   <= lane_ptr_d;
      md5_msg_q    <= md5_msg_d;
      md5_tag_q    <= md5_tag_d;
      md5_valid_q  <= md5_valid_d;
      match_q      <= match_d;
      byte_pos_q   <= byte_pos_d;
      match_msg_q  <= match_msg_d;
    end
  end

`ifdef STRING_MATCH_COUNT_EN
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [3:0]       match_hits;
  logic [CNT_W:0]   match_sum;

  // Count matching lanes per cycle during RUN, saturating at all-ones.
  always_comb begin
    match_hits = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_match[i]) begin
        match_hits = match_hits + 4'd1;
      end
    end
    match_sum     = {1'b0, match_count_q} + (CNT_W+1)'(match_hits);
    match_count_d = match_count_q;
    if (proc_start) begin
      match_count_d = '0;
    end else if (state_q == RUN) begin
      match_count_d = match_sum[CNT_W] ? '1 : match_sum[CNT_W-1:0];
    end
  end

  // Match counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count_q <= '0;
    end else begin
      match_count_q <= match_count_d;
    end
  end

  assign proc_match_count = match_count_q;
`else
  assign proc_match_count = '0;
`endif

  assign proc_done       = (state_q == DONE);
  assign proc_match      = match_q;
  assign proc_byte_pos   = byte_pos_q;
  assign proc_match_char = match_msg_q[MSG_W-1 -: 8];
  assign md5_msg         = md5_msg_q;
  assign md5_tag         = md5_tag_q;
  assign md5_msg_valid   = md5_valid_q;

endmodule

// File: tb/tb_string_process_match_multi.sv
// Scoreboard bench for string_process_match_multi: stimulus pushes the
// expected dispatches and batch results into queues; monitors pop and
// compare whenever the design presents a dispatch or raises done.
module tb_string_process_match_multi;

  localparam int STR_LEN   = 19;
  localparam int NUM_LANES = 2;
  localparam int CNT_W     = 16;
  localparam int MSG_W     = 8 * STR_LEN;

`ifdef STRING_MATCH_COUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic                           clk;
  logic                           reset_n;
  logic                           proc_start;
  logic [CNT_W-1:0]               proc_num_bytes;
  logic [7:0]                     proc_data;
  logic                           proc_data_valid;
  logic                           proc_match_char_next;
  logic [127:0]                   proc_target_hash;
  logic                           proc_done;
  logic                           proc_match;
  logic [CNT_W-1:0]               proc_byte_pos;
  logic [7:0]                     proc_match_char;
  logic [CNT_W-1:0]               proc_match_count;
  logic [MSG_W-1:0]               md5_msg;
  logic [CNT_W-1:0]               md5_tag;
  logic [NUM_LANES-1:0]           md5_msg_valid;
  logic [NUM_LANES*128-1:0]       md5_ret_hash;
  logic [NUM_LANES*MSG_W-1:0]     md5_ret_msg;
  logic [NUM_LANES*CNT_W-1:0]     md5_ret_tag;
  logic [NUM_LANES-1:0]           md5_ret_valid;

  string_process_match_multi #(
    .STR_LEN   (STR_LEN),
    .NUM_LANES (NUM_LANES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .proc_start           (proc_start),
    .proc_num_bytes       (proc_num_bytes),
    .proc_data            (proc_data),
    .proc_data_valid      (proc_data_valid),
    .proc_match_char_next (proc_match_char_next),
    .proc_target_hash     (proc_target_hash),
    .proc_done            (proc_done),
    .proc_match           (proc_match),
    .proc_byte_pos        (proc_byte_pos),
    .proc_match_char      (proc_match_char),
    .proc_match_count     (proc_match_count),
    .md5_msg              (md5_msg),
    .md5_tag              (md5_tag),
    .md5_msg_valid        (md5_msg_valid),
    .md5_ret_hash         (md5_ret_hash),
    .md5_ret_msg          (md5_ret_msg),
    .md5_ret_tag          (md5_ret_tag),
    .md5_ret_valid        (md5_ret_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       lanes;
    logic [CNT_W-1:0] tag;
    logic [MSG_W-1:0] msg;
  } disp_t;

  typedef struct packed {
    logic             match;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] cnt;
  } res_t;

  disp_t disp_q[$];
  res_t  res_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  localparam logic [127:0] TGT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] NM0  = TGT ^ 128'h1;
  localparam logic [127:0] NM1  = TGT ^ {1'b1, 127'h0};
  localparam logic [MSG_W-1:0] M1 = "hello_world_0123456";
  localparam logic [MSG_W-1:0] M5 = "Five_five_five_5555";
  localparam logic [MSG_W-1:0] M6 = "SIXsixSIXsixSIXsix6";

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input logic [1:0] lanes, input logic [CNT_W-1:0] tag, input logic [MSG_W-1:0] msg);
    disp_t d;
    d.lanes = lanes;
    d.tag   = tag;
    d.msg   = msg;
    disp_q.push_back(d);
  endtask

  task automatic push_res(input logic m, input logic [CNT_W-1:0] pos, input logic [CNT_W-1:0] cnt);
    res_t r;
    r.match = m;
    r.pos   = pos;
    r.cnt   = cnt;
    res_q.push_back(r);
  endtask

  task automatic start(input logic [CNT_W-1:0] nb);
    proc_start     = 1'b1;
    proc_num_bytes = nb;
    tick();
    proc_start     = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    proc_data       = b;
    proc_data_valid = 1'b1;
    tick();
    proc_data_valid = 1'b0;
  endtask

  task automatic ret2(input logic [1:0] v,
                      input logic [127:0] h0, input logic [CNT_W-1:0] t0, input logic [MSG_W-1:0] m0,
                      input logic [127:0] h1, input logic [CNT_W-1:0] t1, input logic [MSG_W-1:0] m1);
    md5_ret_valid = v;
    md5_ret_hash  = {h1, h0};
    md5_ret_tag   = {t1, t0};
    md5_ret_msg   = {m1, m0};
    tick();
    md5_ret_valid = '0;
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!proc_done && k < max) begin
      tick();
      k++;
    end
    if (!proc_done) check("done_timeout", proc_done, 1);
  endtask

  // Dispatch monitor: every lane-select pulse must match the next expected dispatch.
  always @(negedge clk) begin : mon_disp
    disp_t e;
    if (|md5_msg_valid) begin
      if (disp_q.size() == 0) begin
        check("unexpected_dispatch", md5_msg_valid, 0);
      end else begin
        e = disp_q.pop_front();
        check("disp_lane", md5_msg_valid, e.lanes);
        check("disp_tag", md5_tag, e.tag);
        check("disp_msg", md5_msg, e.msg);
      end
    end
  end

  // Result monitor: on each rising proc_done compare the batch outcome.
  logic prev_done = 1'b0;
  always @(negedge clk) begin : mon_res
    res_t r;
    if (proc_done && !prev_done) begin
      if (res_q.size() == 0) begin
        check("unexpected_done", proc_done, 0);
      end else begin
        r = res_q.pop_front();
        check("res_match", proc_match, r.match);
        check("res_pos", proc_byte_pos, r.pos);
        check("res_count", proc_match_count, r.cnt);
      end
    end
    prev_done = proc_done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n              = 1'b0;
    proc_start           = 1'b0;
    proc_num_bytes       = '0;
    proc_data            = '0;
    proc_data_valid      = 1'b0;
    proc_match_char_next = 1'b0;
    proc_target_hash     = TGT;
    md5_ret_hash         = '0;
    md5_ret_msg          = '0;
    md5_ret_tag          = '0;
    md5_ret_valid        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", proc_done, 0);
    check("rst_match", proc_match, 0);
    check("rst_pos", proc_byte_pos, 0);
    check("rst_char", proc_match_char, 0);
    check("rst_count", proc_match_count, 0);
    check("rst_valid", md5_msg_valid, 0);
    check("rst_msg", md5_msg, 0);
    check("rst_tag", md5_tag, 0);
    reset_n = 1'b1;
    tick();

    // Batch 1: "abcd", lane 1 returns tag 3 matching.
    push_disp(2'b01, 0, 152'h61);
    push_disp(2'b10, 1, 152'h6162);
    push_disp(2'b01, 2, 152'h616263);
    push_disp(2'b10, 3, 152'h61626364);
    push_res(1'b1, 3, CNT_W'(CNT_ON));
    start(4);
    send("a"); send("b"); send("c"); send("d");
    send("e");                                    // beyond num_bytes: dropped
    ret2(2'b11, NM0, 0, M6, NM1, 1, M6);
    ret2(2'b01, NM0, 2, M6, NM1, 0, M6);
    check("b1_no_match_yet", proc_match, 0);
    ret2(2'b10, NM0, 0, M6, TGT, 3, M1);
    check("b1_match", proc_match, 1);
    check("b1_pos", proc_byte_pos, 3);
    check("b1_done_not_early", proc_done, 0);
    wait_done(5);
    check("b1_done", proc_done, 1);
    ret2(2'b01, TGT, 0, M6, NM1, 0, M6);          // after DONE: ignored
    check("b1_ignored_pos", proc_byte_pos, 3);
    for (int k = 0; k < STR_LEN; k++) begin
      check("b1_char", proc_match_char, M1[MSG_W-1-8*k -: 8]);
      proc_match_char_next = 1'b1;
      tick();
      proc_match_char_next = 1'b0;
    end
    check("b1_char_zero", proc_match_char, 0);

    // Batch 2: start with a same-cycle byte (dropped), simultaneous matches 6 and 5.
    push_disp(2'b01, 0, 152'h41);
    push_disp(2'b10, 1, 152'h4142);
    push_disp(2'b01, 2, 152'h414243);
    push_disp(2'b10, 3, 152'h41424344);
    push_disp(2'b01, 4, 152'h4142434445);
    push_disp(2'b10, 5, 152'h414243444546);
    push_disp(2'b01, 6, 152'h41424344454647);
    push_res(1'b1, 5, CNT_W'(2 * CNT_ON));
    proc_data       = 8'h5a;
    proc_data_valid = 1'b1;
    start(7);
    proc_data_valid = 1'b0;
    send("A"); send("B"); send("C"); send("D"); send("E"); send("F"); send("G");
    ret2(2'b11, NM0, 0, M1, NM1, 1, M1);
    ret2(2'b11, NM1, 2, M1, NM0, 3, M1);
    ret2(2'b11, TGT, 6, M6, TGT, 5, M5);
    check("b2_pos", proc_byte_pos, 5);
    ret2(2'b01, NM0, 4, M1, NM0, 0, M1);
    wait_done(5);
    check("b2_char", proc_match_char, 8'h46);

    // Batch 3: one byte, two returns: ret_count saturates so done still fires.
    push_disp(2'b01, 0, 152'h31);
    push_res(1'b0, 0, 0);
    start(1);
    send("1");
    send("2");
    ret2(2'b11, NM0, 0, M1, NM1, 0, M1);
    wait_done(5);

    // Batch 4: zero bytes: done one cycle after RUN entry, no dispatch.
    push_res(1'b0, 0, 0);
    start(0);
    check("b4_done_early", proc_done, 0);
    send("z");
    check("b4_done", proc_done, 1);

    // Batch 5: reset mid-batch.
    push_disp(2'b01, 0, 152'h78);
    start(4);
    send("x");
    proc_data       = "y";
    proc_data_valid = 1'b1;
    md5_ret_valid   = 2'b01;
    md5_ret_hash    = {NM1, TGT};
    md5_ret_tag     = {16'd0, 16'd0};
    md5_ret_msg     = {M6, M1};
    tick();
    proc_data_valid = 1'b0;
    md5_ret_valid   = '0;
    check("b5_valid_pre", md5_msg_valid, 2'b10);
    check("b5_match_pre", proc_match, 1);
    reset_n = 1'b0;
    #1;
    check("b5_rst_valid", md5_msg_valid, 0);
    check("b5_rst_tag", md5_tag, 0);
    check("b5_rst_msg", md5_msg, 0);
    check("b5_rst_match", proc_match, 0);
    check("b5_rst_char", proc_match_char, 0);
    tick();
    reset_n = 1'b1;
    ret2(2'b11, TGT, 1, M1, TGT, 2, M5);
    send("q");
    ret2(2'b01, TGT, 0, M1, NM1, 0, M1);
    tick();
    check("b5_post_match", proc_match, 0);
    check("b5_post_done", proc_done, 0);
    check("b5_post_count", proc_match_count, 0);

    repeat (3) tick();
    check("disp_q_empty", disp_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/string_process_match_multi.md
# string_process_match_multi

Multi-lane successor of the single-core string buffer/matcher. Shifts incoming bytes into a STR_LEN-character window, dispatches each window round-robin to NUM_LANES pipelined MD5 cores with a byte-position tag, and checks every returned hash against the target. Sits between cmd_parser and the MD5 lane array. Reports done, the lowest-position match, its byte position, and the matched string one character at a time.

## Interface
Parameters:
- STR_LEN, 19, characters per message; message width MSG_W = 8*STR_LEN
- NUM_LANES, 2, MD5 lanes (1..8)
- CNT_W, 16, width of byte counts, positions and tags

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- proc_start  in  1  begin new batch (one-cycle pulse)
- proc_num_bytes  in  CNT_W  bytes in batch
- proc_data  in  8  input byte
- proc_data_valid  in  1  proc_data qualifier
- proc_match_char_next  in  1  shift matched string by one char
- proc_target_hash  in  128  target {a,b,c,d}
- proc_done  out  1  all hashes of batch returned
- proc_match  out  1  at least one match in batch
- proc_byte_pos  out  CNT_W  tag of lowest-position match
- proc_match_char  out  8  current char of matched string
- proc_match_count  out  CNT_W  matches in batch (MATCH_COUNT_EN only)
- md5_msg  out  MSG_W  window to lanes (shared bus)
- md5_tag  out  CNT_W  byte index of message
- md5_msg_valid  out  NUM_LANES  one-hot lane select
- md5_ret_hash  in  NUM_LANES*128  per-lane {a,b,c,d}
- md5_ret_msg  in  NUM_LANES*MSG_W  per-lane returned message
- md5_ret_tag  in  NUM_LANES*CNT_W  per-lane returned tag
- md5_ret_valid  in  NUM_LANES  per-lane return qualifier

## Operation
- States IDLE, RUN, DONE. Reset -> IDLE. proc_start in any state -> RUN, clears window, counters, match state, lane pointer.
- RUN: each proc_data_valid byte with sent_count < num_bytes shifts into window LSB ({window[MSG_W-9:0], byte}); bytes beyond num_bytes and bytes in IDLE/DONE are dropped.
- Dispatch: md5_msg = shifted window, md5_tag = sent_count, md5_msg_valid = one-hot lane_ptr; lane_ptr increments mod NUM_LANES per dispatch. Lanes accept every valid; no backpressure.
- Returns: ret_count += popcount(md5_ret_valid & lanes with valid) each cycle; returns outside RUN ignored.
- Match: lane hash == target -> proc_match set; if first match or tag < stored tag, store tag and message. Simultaneous matches: lowest tag wins.
- RUN -> DONE when ret_count == num_bytes (num_bytes = 0: DONE next cycle).
- DONE: proc_match_char_next shifts stored message left 8, zero-filling; proc_match_char = stored message[MSG_W-1:MSG_W-8]. Ignored outside DONE.

## Timing
- Reset values: all outputs 0, md5_msg_valid = 0.
- md5_msg/md5_tag/md5_msg_valid registered: 1 cycle after accepted byte; valid high one cycle per byte.
- Match outputs update the edge after md5_ret_valid.
- proc_done rises the edge after ret_count reaches num_bytes; held until proc_start or reset.
- proc_start same cycle as proc_data_valid: start wins, byte dropped.
- reset_n assert mid-batch: immediate clear, IDLE; in-flight returns ignored.
- ret_count saturates at num_bytes; extra returns dropped.

## Configuration
- STRING_MATCH_COUNT_EN defined: proc_match_count increments by number of matching lanes per cycle, saturating at all-ones, cleared by proc_start.
- Undefined: counter not built; proc_match_count tied to 0.

## Structure
- Package string_match_pkg: state enum (IDLE/RUN/DONE), default STR_LEN/NUM_LANES/CNT_W constants, hash slice helpers.
- Sub-module hash_compare_lane: per-lane 128-bit compare producing match bit and tag/message pass-through; instantiated NUM_LANES times; lowest-tag select in top.

## Test plan
- NUM_LANES=2, num_bytes=4, bytes "abcd" -> md5_msg_valid 01,10,01,10; tags 0..3; last md5_msg low 32 bits = 0x61626364.
- Lane 1 returns tag 3 with target hash -> proc_match=1, proc_byte_pos=3; after 4 returns proc_done=1.
- Lanes 0 and 1 both match same cycle, tags 6 and 5 -> proc_byte_pos=5; with STRING_MATCH_COUNT_EN proc_match_count=2.
- DONE, 19 pulses of proc_match_char_next -> stored string chars in order, then 0x00.
- num_bytes=0 -> proc_done one cycle after RUN entry, no md5_msg_valid.
- reset_n low mid-batch -> all outputs 0, IDLE; subsequent returns without proc_start ignored.
